// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file.
// Contents:
//   XLEN_DEF, NREGS_DEF - default data width and register count
//   AW_DEF              - address width implied by NREGS_DEF
//   MAX_WPORTS          - widest write-port match vector that hit_idx() accepts
//   regaddr_t           - register address type at the default width
//   hit_idx()           - index of the highest-priority write port that matches an
//                         address, or -1 when no port matches
package rf_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREGS_DEF  = 32;
    localparam int AW_DEF     = $clog2(NREGS_DEF);
    localparam int MAX_WPORTS = 8;

    typedef logic [AW_DEF-1:0] regaddr_t;

    // match[i] = write port i targets the address being read this cycle.
    // A higher port index has priority, so the last set bit wins.
    function automatic int hit_idx(input logic [MAX_WPORTS-1:0] match);
        int r;
        r = -1;
        for (int i = 0; i < MAX_WPORTS; i++) begin
            if (match[i]) begin
                r = i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port of the register file.
// Ports:
//   rs        in   AW           source register address
//   mem_word  in   XLEN         stored word for rs (don't-care when rs == 0)
//   pending   in   1            scoreboard bit for rs
//   regWrite  in   NWRITE       write enables of all write ports
//   rd        in   NWRITE*AW    write addresses of all write ports
//   wd        in   NWRITE*XLEN  write data of all write ports
//   rdata     out  XLEN         read data, with optional same-cycle forwarding
//   rbusy     out  1            source still waiting on an outstanding write
module rf_read_port
    import rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int AW     = AW_DEF,
    parameter int NWRITE = 1,
    parameter int BYPASS = 1
) (
    input  logic [AW-1:0]          rs,
    input  logic [XLEN-1:0]        mem_word,
    input  logic                   pending,
    input  logic [NWRITE-1:0]      regWrite,
    input  logic [NWRITE*AW-1:0]   rd,
    input  logic [NWRITE*XLEN-1:0] wd,
    output logic [XLEN-1:0]        rdata,
    output logic                   rbusy
);

    localparam bit BYP = (BYPASS != 0);

    logic [MAX_WPORTS-1:0] match;
    int                    idx;
    logic                  hit;
    logic [XLEN-1:0]       byp_data;

    always_comb begin
        match = '0;
        for (int i = 0; i < NWRITE; i++) begin
            // x0 is never a forwarding target: its value is fixed at zero.
            match[i] = regWrite[i] && (rd[i*AW +: AW] == rs) && (rs != '0);
        end
        idx = hit_idx(match);
        hit = BYP && (idx >= 0);

        byp_data = '0;
        for (int i = 0; i < NWRITE; i++) begin
            if (i == idx) begin
                byp_data = wd[i*XLEN +: XLEN];
            end
        end

        if (rs == '0) begin
            rdata = '0;
        end else if (hit) begin
            rdata = byp_data;
        end else begin
            rdata = mem_word;
        end

        // A forwarded write satisfies the hazard within this cycle.
        rbusy = (rs != '0) && pending && !hit;
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with a RAW-hazard scoreboard.
// Ports:
//   clk         in   1            clock, all state changes on posedge
//   rst         in   1            synchronous active-high reset (clears data and pending)
//   regWrite    in   NWRITE       per-port write enable
//   rd          in   NWRITE*AW    per-port destination register
//   wd          in   NWRITE*XLEN  per-port write data
//   rs          in   NREAD*AW     per-port source register
//   rdata       out  NREAD*XLEN   per-port combinational read data
//   rbusy       out  NREAD        source has a pending write not satisfied this cycle
//   issueValid  in   1            an issued instruction will write issueRd
//   issueRd     in   AW           destination of the issued instruction
// NWRITE must not exceed rf_pkg::MAX_WPORTS.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NWRITE-1:0]      regWrite,
    input  logic [NWRITE*AW-1:0]   rd,
    input  logic [NWRITE*XLEN-1:0] wd,
    input  logic [NREAD*AW-1:0]    rs,
    output logic [NREAD*XLEN-1:0]  rdata,
    output logic [NREAD-1:0]       rbusy,
    input  logic                   issueValid,
    input  logic [AW-1:0]          issueRd
);

    // x0 has no storage; reads of it are forced to zero in the read ports.
    logic [XLEN-1:0]  mem [1:NREGS-1];
    logic [NREGS-1:0] pending_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 1; r < NREGS; r++) begin
                mem[r] <= '0;
            end
            pending_reg <= '0;
        end else begin
            // Ascending port order: a later (higher-index) port overrides an
            // earlier one targeting the same register.
            for (int i = 0; i < NWRITE; i++) begin
                if (regWrite[i] && (rd[i*AW +: AW] != '0)) begin
                    mem[rd[i*AW +: AW]]         <= wd[i*XLEN +: XLEN];
                    pending_reg[rd[i*AW +: AW]] <= 1'b0;
                end
            end
            // Placed after the write clears so a same-cycle issue keeps the bit
            // set: the newly issued producer is still outstanding.
            if (issueValid && (issueRd != '0)) begin
                pending_reg[issueRd] <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_read
        logic [AW-1:0]   rs_addr;
        logic [XLEN-1:0] mem_word;

        assign rs_addr = rs[gi*AW +: AW];

        always_comb begin
            mem_word = '0;
            if (rs_addr != '0) begin
                mem_word = mem[rs_addr];
            end
        end

        rf_read_port #(
            .XLEN   (XLEN),
            .AW     (AW),
            .NWRITE (NWRITE),
            .BYPASS (BYPASS)
        ) u_read_port (
            .rs       (rs_addr),
            .mem_word (mem_word),
            .pending  (pending_reg[rs_addr]),
            .regWrite (regWrite),
            .rd       (rd),
            .wd       (wd),
            .rdata    (rdata[gi*XLEN +: XLEN]),
            .rbusy    (rbusy[gi])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: one forwarding instance and one
// non-forwarding instance, both with two write ports, driven by the same inputs.
module tb_reg_file_mp;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int AW     = 5;
    localparam int NREAD  = 2;
    localparam int NWRITE = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NWRITE-1:0]      regWrite;
    logic [NWRITE*AW-1:0]   rd;
    logic [NWRITE*XLEN-1:0] wd;
    logic [NREAD*AW-1:0]    rs;
    logic [NREAD*XLEN-1:0]  rdata;
    logic [NREAD-1:0]       rbusy;
    logic [NREAD*XLEN-1:0]  rdata_nb;
    logic [NREAD-1:0]       rbusy_nb;
    logic                   issueValid;
    logic [AW-1:0]          issueRd;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    reg_file_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE), .BYPASS(1)
    ) dut (
        .clk(clk), .rst(rst), .regWrite(regWrite), .rd(rd), .wd(wd), .rs(rs),
        .rdata(rdata), .rbusy(rbusy), .issueValid(issueValid), .issueRd(issueRd)
    );

    reg_file_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE), .BYPASS(0)
    ) dut_nb (
        .clk(clk), .rst(rst), .regWrite(regWrite), .rd(rd), .wd(wd), .rs(rs),
        .rdata(rdata_nb), .rbusy(rbusy_nb), .issueValid(issueValid), .issueRd(issueRd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_w(input int p, input logic en, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        regWrite[p]        = en;
        rd[p*AW +: AW]     = a;
        wd[p*XLEN +: XLEN] = d;
    endtask

    task automatic idle();
        regWrite   = '0;
        rd         = '0;
        wd         = '0;
        issueValid = 1'b0;
        issueRd    = '0;
        rst        = 1'b0;
    endtask

    // Advance past the next rising edge; inputs change 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rs  = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // 1. Write x5=7, then reset (with a competing write and issue).
        set_w(0, 1'b1, 5'd5, 32'd7);
        tick();
        idle();
        rs[0 +: AW] = 5'd5;
        #1;
        check("pre_reset_x5", rdata[0 +: XLEN], 32'd7);
        rst = 1'b1;
        set_w(0, 1'b1, 5'd5, 32'd77);
        issueValid = 1'b1;
        issueRd    = 5'd5;
        tick();
        idle();
        #1;
        check("reset_rdata0", rdata[0 +: XLEN], 32'd0);
        check("reset_rbusy0", {31'd0, rbusy[0]}, 32'd0);
        check("reset_rdata0_nb", rdata_nb[0 +: XLEN], 32'd0);

        // 2. Basic write / read, and x0 stays zero.
        set_w(0, 1'b1, 5'd5, 32'd42);
        tick();
        idle();
        #1;
        check("x5_after_write", rdata[0 +: XLEN], 32'd42);
        set_w(0, 1'b1, 5'd0, 32'd99);
        issueValid = 1'b1;
        issueRd    = 5'd0;
        tick();
        idle();
        rs[0 +: AW] = 5'd0;
        #1;
        check("x0_read_zero", rdata[0 +: XLEN], 32'd0);
        check("x0_rbusy_zero", {31'd0, rbusy[0]}, 32'd0);

        // 3. Same-cycle bypass on read port 1.
        set_w(0, 1'b1, 5'd10, 32'd100);
        rs[AW +: AW] = 5'd10;
        #1;
        check("bypass_x10", rdata[XLEN +: XLEN], 32'd100);
        check("nobypass_x10_old", rdata_nb[XLEN +: XLEN], 32'd0);
        tick();
        idle();
        #1;
        check("x10_stored", rdata[XLEN +: XLEN], 32'd100);
        check("x10_stored_nb", rdata_nb[XLEN +: XLEN], 32'd100);

        // 4. Two ports write x15: port 1 wins for both forwarding and storage.
        set_w(0, 1'b1, 5'd15, 32'd1);
        set_w(1, 1'b1, 5'd15, 32'd2);
        rs[AW +: AW] = 5'd15;
        #1;
        check("bypass_prio_x15", rdata[XLEN +: XLEN], 32'd2);
        tick();
        idle();
        rs[0 +: AW] = 5'd15;
        #1;
        check("x15_prio", rdata[0 +: XLEN], 32'd2);
        check("x15_prio_nb", rdata_nb[0 +: XLEN], 32'd2);

        // 5. Issue x7, stays busy until written.
        issueValid = 1'b1;
        issueRd    = 5'd7;
        tick();
        idle();
        rs[0 +: AW] = 5'd7;
        #1;
        check("x7_busy", {31'd0, rbusy[0]}, 32'd1);
        tick();
        check("x7_still_busy", {31'd0, rbusy[0]}, 32'd1);
        set_w(0, 1'b1, 5'd7, 32'd5);
        #1;
        check("x7_wcycle_rbusy", {31'd0, rbusy[0]}, 32'd0);
        check("x7_wcycle_rdata", rdata[0 +: XLEN], 32'd5);
        check("x7_wcycle_rbusy_nb", {31'd0, rbusy_nb[0]}, 32'd1);
        check("x7_wcycle_rdata_nb", rdata_nb[0 +: XLEN], 32'd0);
        tick();
        idle();
        #1;
        check("x7_after_rbusy", {31'd0, rbusy[0]}, 32'd0);
        check("x7_after_rbusy_nb", {31'd0, rbusy_nb[0]}, 32'd0);
        check("x7_after_rdata", rdata[0 +: XLEN], 32'd5);

        // 6. Issue and write x8 in the same cycle: data lands, pending stays.
        issueValid = 1'b1;
        issueRd    = 5'd8;
        set_w(0, 1'b1, 5'd8, 32'd33);
        tick();
        idle();
        rs[0 +: AW] = 5'd8;
        #1;
        check("x8_data", rdata[0 +: XLEN], 32'd33);
        check("x8_busy", {31'd0, rbusy[0]}, 32'd1);
        check("x8_busy_nb", {31'd0, rbusy_nb[0]}, 32'd1);
        set_w(1, 1'b1, 5'd8, 32'd44);
        tick();
        idle();
        #1;
        check("x8_cleared", {31'd0, rbusy[0]}, 32'd0);
        check("x8_new_data", rdata[0 +: XLEN], 32'd44);

        // Reset mid-operation discards pending state.
        issueValid = 1'b1;
        issueRd    = 5'd9;
        tick();
        idle();
        rs[0 +: AW] = 5'd9;
        #1;
        check("x9_busy", {31'd0, rbusy[0]}, 32'd1);
        rst = 1'b1;
        tick();
        idle();
        #1;
        check("x9_reset_clears", {31'd0, rbusy[0]}, 32'd0);
        rs[0 +: AW] = 5'd15;
        #1;
        check("x15_reset_clears", rdata[0 +: XLEN], 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
